// File: rtl/tcp_vlg_ack_sched.sv
// tcp_vlg_ack_sched: TCP RX ACK scheduler (delayed ACK/timer/ACK_EVERY built only with TCP_VLG_DELAYED_ACK_EN)
module tcp_vlg_ack_sched #(
  parameter int ACK_DELAY_TICKS = 25000,
  parameter int ACK_EVERY       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [31:0] init_ack,
  input  logic        close,
  input  logic        seg_val,
  input  logic [31:0] seg_seq,
  input  logic [15:0] seg_len,
  input  logic        seg_psh,
  input  logic        seg_fin,
  output logic        ack_req,
  input  logic        ack_ack,
  output logic [31:0] loc_ack,
  output logic        ooo,
  output logic        fin_rcvd
);
  typedef enum logic [1:0] {IDLE, WAIT, PEND, REQ} state_t;
  state_t      state_q, state_d;
  logic [31:0] loc_ack_q, loc_ack_d;
  logic        ooo_q, ooo_d;
  logic        fin_q, fin_d;
  logic        in_order, mis;
  logic [31:0] adv;
  assign in_order = seg_val && seg_seq == loc_ack_q && (seg_len != 16'd0 || seg_fin);
  assign mis      = seg_val && seg_seq != loc_ack_q;
  assign adv      = loc_ack_q + {16'd0, seg_len} + {31'd0, seg_fin};
  assign ack_req  = state_q == REQ;
  assign loc_ack  = loc_ack_q;
  assign ooo      = ooo_q;
  assign fin_rcvd = fin_q;
  // connection state, ACK number and status flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      loc_ack_q <= 32'd0;
      ooo_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      loc_ack_q <= loc_ack_d;
      ooo_q     <= ooo_d;
      fin_q     <= fin_d;
    end
`ifdef TCP_VLG_DELAYED_ACK_EN
  localparam int PW = $clog2(ACK_EVERY + 1);
  localparam int TW = $clog2(ACK_DELAY_TICKS);
  logic [PW-1:0] pend_q, pend_d, pend_base, pend_inc;
  logic [TW-1:0] timer_q, timer_d;
  state_t        base;
  assign pend_inc = pend_base == '1 ? pend_base : pend_base + PW'(1);
  // pending-segment count and delayed-ACK timer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend_q  <= '0;
      timer_q <= '0;
    end else begin
      pend_q  <= pend_d;
      timer_q <= timer_d;
    end
  // next state: close > init > ack_ack consumes REQ > timer expiry > segment classification
  always_comb begin
    state_d   = state_q;
    loc_ack_d = loc_ack_q;
    ooo_d     = 1'b0;
    fin_d     = fin_q;
    pend_d    = pend_q;
    timer_d   = timer_q;
    base      = state_q;
    pend_base = pend_q;
    if (close) begin
      state_d = IDLE;
      fin_d   = 1'b0;
      pend_d  = '0;
      timer_d = '0;
    end else if (init) begin
      state_d   = WAIT;
      loc_ack_d = init_ack;
      fin_d     = 1'b0;
      pend_d    = '0;
      timer_d   = '0;
    end else if (state_q != IDLE) begin
      if (state_q == REQ && ack_ack) begin
        base      = WAIT;
        pend_base = '0;
        timer_d   = '0;
      end
      state_d = base;
      pend_d  = pend_base;
      if (base == PEND) begin
        if (timer_q == TW'(ACK_DELAY_TICKS - 2)) state_d = REQ;
        else timer_d = timer_q + TW'(1);
      end
      if (mis) begin
        ooo_d   = 1'b1;
        state_d = REQ;
      end else if (in_order) begin
        loc_ack_d = adv;
        fin_d     = fin_q | seg_fin;
        pend_d    = pend_inc;
        if (seg_psh || seg_fin || int'(pend_base) + 1 >= ACK_EVERY) state_d = REQ;
        else if (base == WAIT) begin
          state_d = PEND;
          timer_d = '0;
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = seg_psh ^ (ACK_DELAY_TICKS + ACK_EVERY > 0);
  // next state: close > init > ack_ack consumes REQ > any data/FIN or out-of-order segment requests an ACK
  always_comb begin
    state_d   = state_q;
    loc_ack_d = loc_ack_q;
    ooo_d     = 1'b0;
    fin_d     = fin_q;
    if (close) begin
      state_d = IDLE;
      fin_d   = 1'b0;
    end else if (init) begin
      state_d   = WAIT;
      loc_ack_d = init_ack;
      fin_d     = 1'b0;
    end else if (state_q != IDLE) begin
      if (state_q == REQ && ack_ack) state_d = WAIT;
      if (mis) begin
        ooo_d   = 1'b1;
        state_d = REQ;
      end else if (in_order) begin
        loc_ack_d = adv;
        fin_d     = fin_q | seg_fin;
        state_d   = REQ;
      end
    end
  end
`endif
endmodule

// File: tb/tb_tcp_vlg_ack_sched.sv
// tb_tcp_vlg_ack_sched: directed self-checking bench for tcp_vlg_ack_sched
module tb_tcp_vlg_ack_sched;
  localparam int D = 20;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0, close = 1'b0, seg_val = 1'b0, seg_psh = 1'b0, seg_fin = 1'b0, ack_ack = 1'b0;
  logic [31:0] init_ack = '0, seg_seq = '0, loc_ack;
  logic [15:0] seg_len = '0;
  logic        ack_req, ooo, fin_rcvd;
  int          total = 0, bad = 0;
  tcp_vlg_ack_sched #(.ACK_DELAY_TICKS(D), .ACK_EVERY(2)) dut (
    .clk(clk), .rst(rst), .init(init), .init_ack(init_ack), .close(close),
    .seg_val(seg_val), .seg_seq(seg_seq), .seg_len(seg_len), .seg_psh(seg_psh), .seg_fin(seg_fin),
    .ack_req(ack_req), .ack_ack(ack_ack), .loc_ack(loc_ack), .ooo(ooo), .fin_rcvd(fin_rcvd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_init(input logic [31:0] a);
    init = 1'b1;
    init_ack = a;
    cyc();
    init = 1'b0;
  endtask
  task automatic seg(input logic [31:0] s, input logic [15:0] l, input logic p, input logic f);
    seg_val = 1'b1;
    seg_seq = s;
    seg_len = l;
    seg_psh = p;
    seg_fin = f;
    cyc();
    seg_val = 1'b0;
    seg_psh = 1'b0;
    seg_fin = 1'b0;
  endtask
  task automatic do_ack();
    ack_ack = 1'b1;
    cyc();
    ack_ack = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_ack_req", ack_req, 0);
    chk("rst_loc_ack", loc_ack, 0);
    chk("rst_ooo", ooo, 0);
    chk("rst_fin", fin_rcvd, 0);
    rst = 1'b1;
    cyc();
    do_init(32'h1000);
    chk("t1_init_loc", loc_ack, 32'h1000);
    chk("t1_init_req", ack_req, 0);
    seg(32'h1000, 16'd100, 1'b0, 1'b0);
    chk("t1_loc", loc_ack, 32'h1064);
`ifdef TCP_VLG_DELAYED_ACK_EN
    chk("t1_req_n1", ack_req, 0);
    repeat (D - 2) cyc();
    chk("t1_req_early", ack_req, 0);
    cyc();
    chk("t1_req_timeout", ack_req, 1);
`else
    chk("t1_req_imm", ack_req, 1);
`endif
    do_ack();
    chk("t1_req_drop", ack_req, 0);
    seg(32'h1064, 16'd100, 1'b0, 1'b0);
`ifdef TCP_VLG_DELAYED_ACK_EN
    chk("t2_req_first", ack_req, 0);
`else
    chk("t2_req_first", ack_req, 1);
`endif
    seg(32'h10C8, 16'd100, 1'b0, 1'b0);
    chk("t2_req_second", ack_req, 1);
    chk("t2_loc", loc_ack, 32'h112C);
    do_ack();
    chk("t2_req_drop", ack_req, 0);
    do_init(32'h2000);
    seg(32'h2500, 16'd50, 1'b0, 1'b0);
    chk("t3_ooo", ooo, 1);
    chk("t3_req", ack_req, 1);
    chk("t3_loc", loc_ack, 32'h2000);
    cyc();
    chk("t3_ooo_pulse", ooo, 0);
    chk("t3_req_held", ack_req, 1);
    do_ack();
    do_init(32'hFFFF_FFF0);
    seg(32'hFFFF_FFF0, 16'd32, 1'b1, 1'b0);
    chk("t4_wrap", loc_ack, 32'h0000_0010);
    chk("t4_req", ack_req, 1);
    do_ack();
    seg(32'h10, 16'd0, 1'b0, 1'b1);
    chk("t5_loc", loc_ack, 32'h11);
    chk("t5_fin", fin_rcvd, 1);
    chk("t5_req", ack_req, 1);
    seg(32'h11, 16'd0, 1'b0, 1'b0);
    chk("t5_pure_loc", loc_ack, 32'h11);
    chk("t5_pure_req", ack_req, 1);
    close = 1'b1;
    cyc();
    close = 1'b0;
    chk("t5_close_req", ack_req, 0);
    chk("t5_close_fin", fin_rcvd, 0);
    seg(32'h11, 16'd10, 1'b1, 1'b0);
    chk("t5_idle_loc", loc_ack, 32'h11);
    chk("t5_idle_req", ack_req, 0);
    chk("t5_idle_ooo", ooo, 0);
    do_init(32'h3000);
    seg(32'h3000, 16'd10, 1'b1, 1'b0);
    chk("t6_pre_req", ack_req, 1);
    ack_ack = 1'b1;
    seg(32'h300A, 16'd10, 1'b0, 1'b0);
    ack_ack = 1'b0;
    chk("t6_sim_loc", loc_ack, 32'h3014);
`ifdef TCP_VLG_DELAYED_ACK_EN
    chk("t6_sim_req", ack_req, 0);
`else
    chk("t6_sim_req", ack_req, 1);
`endif
    seg(32'h3014, 16'd10, 1'b0, 1'b0);
    chk("t6_pend1_req", ack_req, 1);
    chk("t6_pend1_loc", loc_ack, 32'h301E);
    do_ack();
    seg(32'h301E, 16'd10, 1'b0, 1'b0);
    repeat (3) cyc();
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_req", ack_req, 0);
    chk("t6_arst_loc", loc_ack, 0);
    chk("t6_arst_ooo", ooo, 0);
    chk("t6_arst_fin", fin_rcvd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
